// File: rtl/pipe_stage6.sv
// pipe_stage6: per-lane, per-element rescaling output accumulator that hands the finished tile out over valid/ready.
// Optional feature: define PIPE_STAGE6_SAT_EN for saturating arithmetic and the sticky per-lane sat_o output.
module pipe_stage6 #(
    parameter int WIDTH         = 16,
    parameter int FRAC          = 8,
    parameter int para          = 8,
    parameter int parallel_size = 2,
    parameter int tile_size     = 128
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                valid_i,
    output logic                                                ready_o,
    input  logic [parallel_size-1:0][WIDTH-1:0]                 alpha_i,
    input  logic [parallel_size-1:0][WIDTH-1:0]                 _alpha_i,
    input  logic [parallel_size-1:0][WIDTH-1:0]                 beta_i,
    input  logic [parallel_size-1:0]                            U_add,
    input  logic [parallel_size-1:0][tile_size-1:0][WIDTH-1:0]  K_i,
    input  logic                                                finished_i,
    output logic                                                out_valid_o,
    input  logic                                                out_ready_i,
    output logic [parallel_size-1:0][tile_size-1:0][WIDTH-1:0]  O_o,
    output logic [parallel_size-1:0][para-1:0]                  upd_cnt_o,
    output logic                                                busy_o
`ifdef PIPE_STAGE6_SAT_EN
    ,
    output logic [parallel_size-1:0]                            sat_o
`endif
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             clip;
    } upd_t;

    typedef logic [parallel_size-1:0][tile_size-1:0][WIDTH-1:0] tile_t;
    typedef logic [parallel_size-1:0][para-1:0]                 cnt_t;

    localparam logic signed [2*WIDTH:0] SAT_HI = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH:0] SAT_LO = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t state_q, state_d;
    tile_t  acc_q, acc_d, acc_new;
    tile_t  o_q, o_d;
    cnt_t   cnt_q, cnt_d, cnt_new;
    cnt_t   cnt_out_q, cnt_out_d;
    upd_t   upd;
`ifdef PIPE_STAGE6_SAT_EN
    logic [parallel_size-1:0] sat_acc_q, sat_acc_d, sat_out_q, sat_out_d, clip_new;
`endif

    // R(scale*acc + beta*k): full-precision sum, floor shift by FRAC, then reduce to WIDTH.
    function automatic upd_t rescale(input logic [WIDTH-1:0] scale, input logic [WIDTH-1:0] acc,
                                     input logic [WIDTH-1:0] beta, input logic [WIDTH-1:0] k,
                                     input logic add);
        logic signed [2*WIDTH-1:0] prod_a, prod_b;
        logic signed [2*WIDTH:0]   sum, shifted;
        upd_t                      r;
        prod_a = $signed({{WIDTH{scale[WIDTH-1]}}, scale}) * $signed({{WIDTH{acc[WIDTH-1]}}, acc});
        prod_b = add ? $signed({{WIDTH{beta[WIDTH-1]}}, beta}) * $signed({{WIDTH{k[WIDTH-1]}}, k})
                     : '0;
        sum     = {prod_a[2*WIDTH-1], prod_a} + {prod_b[2*WIDTH-1], prod_b};
        shifted = sum >>> FRAC;
        r.clip  = 1'b0;
`ifdef PIPE_STAGE6_SAT_EN
        if (shifted > SAT_HI) begin
            r.val  = {1'b0, {(WIDTH-1){1'b1}}};
            r.clip = 1'b1;
        end else if (shifted < SAT_LO) begin
            r.val  = {1'b1, {(WIDTH-1){1'b0}}};
            r.clip = 1'b1;
        end else begin
            r.val = shifted[WIDTH-1:0];
        end
`else
        r.val = shifted[WIDTH-1:0];
`endif
        return r;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_new = '0;
        cnt_new = '0;
        upd     = '0;
`ifdef PIPE_STAGE6_SAT_EN
        clip_new = '0;
`endif
        for (int p = 0; p < parallel_size; p++) begin
            cnt_new[p] = (U_add[p] && cnt_q[p] != '1) ? cnt_q[p] + para'(1) : cnt_q[p];
            for (int t = 0; t < tile_size; t++) begin
                upd = rescale(U_add[p] ? alpha_i[p] : _alpha_i[p], acc_q[p][t],
                              beta_i[p], K_i[p][t], U_add[p]);
                acc_new[p][t] = upd.val;
`ifdef PIPE_STAGE6_SAT_EN
                clip_new[p] = clip_new[p] | upd.clip;
`endif
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        cnt_out_d = cnt_out_q;
`ifdef PIPE_STAGE6_SAT_EN
        sat_acc_d = sat_acc_q;
        sat_out_d = sat_out_q;
`endif
        case (state_q)
            IDLE, ACC: begin
                if (valid_i) begin
                    if (finished_i) begin
                        // Publish the post-update tile and restart accumulation from zero.
                        state_d   = HOLD;
                        o_d       = acc_new;
                        cnt_out_d = cnt_new;
                        acc_d     = '0;
                        cnt_d     = '0;
`ifdef PIPE_STAGE6_SAT_EN
                        sat_out_d = sat_acc_q | clip_new;
                        sat_acc_d = '0;
`endif
                    end else begin
                        state_d = ACC;
                        acc_d   = acc_new;
                        cnt_d   = cnt_new;
`ifdef PIPE_STAGE6_SAT_EN
                        sat_acc_d = sat_acc_q | clip_new;
`endif
                    end
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = IDLE;
`ifdef PIPE_STAGE6_SAT_EN
                    sat_out_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the accumulator arrays are reset because a mid-sequence reset must discard partial sums.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            o_q       <= '0;
            cnt_out_q <= '0;
`ifdef PIPE_STAGE6_SAT_EN
            sat_acc_q <= '0;
            sat_out_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            cnt_out_q <= cnt_out_d;
`ifdef PIPE_STAGE6_SAT_EN
            sat_acc_q <= sat_acc_d;
            sat_out_q <= sat_out_d;
`endif
        end
    end

    assign ready_o     = (state_q != HOLD);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = (state_q == HOLD);
    assign O_o         = o_q;
    assign upd_cnt_o   = cnt_out_q;
`ifdef PIPE_STAGE6_SAT_EN
    assign sat_o       = sat_out_q;
`endif

endmodule
